// File: rtl/acia_tx.sv
// UART transmitter: 4-entry byte FIFO feeding an 8N1 serialiser.
// Bit timing uses the same sym_cnt rate counter as acia_rx.
module acia_tx #(
    parameter int SCW     = 16,
    parameter int sym_cnt = 40000,
    parameter int FAW     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_dat,
    input  logic       tx_stb,
    output logic       tx_full,
    output logic       tx_ovf,
    output logic       tx_busy,
    output logic       tx_serial
);

    localparam int              DEPTH    = 2 ** FAW;
    localparam logic [SCW-1:0]  RELOAD   = SCW'(sym_cnt - 1);
    localparam logic [SCW-1:0]  CNT_ONE  = SCW'(1);
    localparam logic [SCW-1:0]  CNT_ZERO = SCW'(0);
    localparam logic [FAW-1:0]  PTR_ONE  = FAW'(1);
    localparam logic [FAW:0]    OCC_ONE  = (FAW+1)'(1);
    localparam logic [FAW:0]    OCC_ZERO = (FAW+1)'(0);
    localparam logic [FAW:0]    OCC_FULL = (FAW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]     mem_r [DEPTH];
    logic [FAW-1:0] wr_ptr_r;
    logic [FAW-1:0] rd_ptr_r;
    logic [FAW:0]   count_r;
    state_t         state_r;
    logic [SCW-1:0] cnt_r;
    logic [2:0]     bit_idx_r;
    logic [7:0]     shift_r;
    logic           full_r;
    logic           ovf_r;
    logic           busy_r;
    logic           serial_r;

    logic           push_s;
    logic           pop_s;
    logic [FAW:0]   count_next_s;
    logic [7:0]     rd_dat_s;

    assign push_s   = tx_stb && !full_r;
    assign rd_dat_s = mem_r[rd_ptr_r];

    // Pop decision: the FSM takes a byte when idle, or when a stop bit ends with data waiting.
    always_comb begin
        pop_s = 1'b0;
        if (count_r != OCC_ZERO) begin
            if (state_r == IDLE) begin
                pop_s = 1'b1;
            end else if ((state_r == STOP) && (cnt_r == CNT_ZERO)) begin
                pop_s = 1'b1;
            end else begin
                pop_s = 1'b0;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // Next occupancy; a simultaneous push and pop cancel out.
    always_comb begin
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + OCC_ONE;
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - OCC_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // FIFO storage; no reset needed since only written slots are ever read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= tx_dat;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {FAW{1'b0}};
            rd_ptr_r <= {FAW{1'b0}};
            count_r  <= OCC_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_next_s;
        end
    end

    // Framing FSM: every state lasts exactly sym_cnt cycles via the reload counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        shift_r <= rd_dat_s;
                        cnt_r   <= RELOAD;
                        state_r <= START;
                    end
                end
                START: begin
                    if (cnt_r == CNT_ZERO) begin
                        cnt_r     <= RELOAD;
                        bit_idx_r <= 3'd0;
                        state_r   <= DATA;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_r == CNT_ZERO) begin
                        shift_r <= {1'b0, shift_r[7:1]};
                        cnt_r   <= RELOAD;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_r == CNT_ZERO) begin
                        if (pop_s) begin
                            shift_r <= rd_dat_s;
                            cnt_r   <= RELOAD;
                            state_r <= START;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    // Line driver lags the state by one edge so the line comes straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            serial_r <= 1'b1;
        end else begin
            case (state_r)
                START:   serial_r <= 1'b0;
                DATA:    serial_r <= shift_r[0];
                default: serial_r <= 1'b1;
            endcase
        end
    end

    // Status flags; full tracks the occupancy the current edge is about to commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_r <= 1'b0;
            ovf_r  <= 1'b0;
            busy_r <= 1'b0;
        end else begin
            full_r <= (count_next_s == OCC_FULL);
            ovf_r  <= tx_stb && full_r;
            busy_r <= (state_r != IDLE) || (count_r != OCC_ZERO);
        end
    end

    assign tx_full   = full_r;
    assign tx_ovf    = ovf_r;
    assign tx_busy   = busy_r;
    assign tx_serial = serial_r;

endmodule

// File: tb/tb_acia_tx.sv
// Scoreboard bench for acia_tx: queued expected bytes, a line monitor that
// checks every cycle of each frame, plus directed flag/latency/reset checks.
module tb_acia_tx;

    localparam int S  = 8;
    localparam int S2 = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_dat = 8'h00;
    logic       tx_stb = 1'b0;
    logic       tx_full, tx_ovf, tx_busy, tx_serial;
    logic [7:0] tx_dat2 = 8'h00;
    logic       tx_stb2 = 1'b0;
    logic       tx_full2, tx_ovf2, tx_busy2, tx_serial2;

    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q [$];
    int         start_q [$];

    acia_tx #(.SCW(4), .sym_cnt(S), .FAW(2)) dut (
        .clk(clk), .rst(rst), .tx_dat(tx_dat), .tx_stb(tx_stb),
        .tx_full(tx_full), .tx_ovf(tx_ovf), .tx_busy(tx_busy), .tx_serial(tx_serial)
    );

    acia_tx #(.SCW(2), .sym_cnt(S2), .FAW(2)) dut2 (
        .clk(clk), .rst(rst), .tx_dat(tx_dat2), .tx_stb(tx_stb2),
        .tx_full(tx_full2), .tx_ovf(tx_ovf2), .tx_busy(tx_busy2), .tx_serial(tx_serial2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic ok, input int got, input int want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Stimulus phase is always 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        tx_dat = d;
        tx_stb = 1'b1;
        exp_q.push_back(d);
        step(1);
        tx_stb = 1'b0;
    endtask

    task automatic push_reject(input logic [7:0] d);
        tx_dat = d;
        tx_stb = 1'b1;
        step(1);
        tx_stb = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy !== 1'b0) && n < budget) begin
            step(1);
            n++;
        end
        chk("idle_timeout", n < budget, n, budget);
    endtask

    // Monitor: on a start bit, pop the expected byte and compare every cycle of the frame.
    initial begin
        logic [7:0] e;
        int         bad;
        int         bitn;
        logic       want;
        logic       aborted;
        forever begin
            @(negedge clk);
            if (rst && tx_serial === 1'b0) begin
                start_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1'b0, 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    bad = 0;
                    aborted = 1'b0;
                    for (int i = 0; i < 10 * S; i++) begin
                        if (i > 0) @(negedge clk);
                        if (!rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        bitn = i / S;
                        if (bitn == 0) want = 1'b0;
                        else if (bitn == 9) want = 1'b1;
                        else want = e[bitn-1];
                        if (tx_serial !== want) bad++;
                    end
                    if (!aborted) chk("frame", bad == 0, bad, 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pc;
        int n;
        int target;
        int drop_cyc;
        int guard;
        logic seen;
        logic [7:0] d;
        logic want;
        int bad;
        int bitn;

        // Reset state
        step(3);
        chk("rst_serial", tx_serial === 1'b1, tx_serial, 1);
        chk("rst_full",   tx_full === 1'b0, tx_full, 0);
        chk("rst_ovf",    tx_ovf === 1'b0, tx_ovf, 0);
        chk("rst_busy",   tx_busy === 1'b0, tx_busy, 0);
        rst = 1'b1;
        step(2);

        // Single byte: latency, busy span, idle line afterwards
        start_q.delete();
        pc = cyc + 1;
        push(8'h55);
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (tx_busy === 1'b1) begin
                n++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
            step(1);
        end
        chk("busy_span", n == 10 * S + 1, n, 10 * S + 1);
        wait_idle(500);
        chk("start_latency", start_q.size() >= 1 && start_q[0] - pc == 2,
            (start_q.size() >= 1) ? start_q[0] - pc : -1, 2);
        step(3);
        chk("idle_high", tx_serial === 1'b1, tx_serial, 1);

        // Back-to-back frames, full flag, overflow, push colliding with pop
        start_q.delete();
        push(8'hA3);
        step(4);
        push(8'h00);
        push(8'hFF);
        push(8'h81);
        chk("full_at_3", tx_full === 1'b0, tx_full, 0);
        push(8'h3E);
        chk("full_at_4", tx_full === 1'b1, tx_full, 1);
        push_reject(8'h42);
        chk("ovf_pulse", tx_ovf === 1'b1, tx_ovf, 1);
        step(1);
        chk("ovf_one_cycle", tx_ovf === 1'b0, tx_ovf, 0);
        chk("full_hold", tx_full === 1'b1, tx_full, 1);
        target = start_q[0] + 10 * S - 2;
        guard = 0;
        while (cyc != target && guard < 200) begin
            step(1);
            guard++;
        end
        chk("reach_pop_edge", cyc == target, cyc, target);
        push_reject(8'h99);
        drop_cyc = cyc;
        chk("ovf_at_pop", tx_ovf === 1'b1, tx_ovf, 1);
        chk("full_drop_at_pop", tx_full === 1'b0, tx_full, 0);
        wait_idle(2000);
        chk("frame_count", start_q.size() == 5, start_q.size(), 5);
        if (start_q.size() == 5) begin
            chk("full_drop_time", start_q[1] - drop_cyc == 1, start_q[1] - drop_cyc, 1);
            for (int k = 0; k < 4; k++)
                chk("no_gap", start_q[k+1] - start_q[k] == 10 * S,
                    start_q[k+1] - start_q[k], 10 * S);
        end

        // Reset during DATA bit 3 of 0x0F
        step(5);
        pc = cyc + 1;
        push(8'h0F);
        target = pc + 2 + 4 * S + 2;
        while (cyc < target) step(1);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_serial", tx_serial === 1'b1, tx_serial, 1);
        chk("async_rst_busy",   tx_busy === 1'b0, tx_busy, 0);
        chk("async_rst_full",   tx_full === 1'b0, tx_full, 0);
        chk("async_rst_ovf",    tx_ovf === 1'b0, tx_ovf, 0);
        step(2);
        rst = 1'b1;
        step(2);
        push(8'h3C);
        wait_idle(500);

        // Randomised traffic, pushes only while there is space
        for (int i = 0; i < 30; i++) begin
            guard = 0;
            while (tx_full === 1'b1 && guard < 200) begin
                step(1);
                guard++;
            end
            push(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) step($urandom_range(0, 120));
            else step($urandom_range(0, 3));
        end
        wait_idle(5000);

        // Minimum rate instance: exact waveform of 0xC6 and busy span
        d = 8'hC6;
        tx_dat2 = d;
        tx_stb2 = 1'b1;
        step(1);
        tx_stb2 = 1'b0;
        bad = 0;
        n = 0;
        for (int k = 0; k < 26; k++) begin
            bitn = (k - 2) / S2;
            if (k < 2 || k - 2 >= 10 * S2) want = 1'b1;
            else if (bitn == 0) want = 1'b0;
            else if (bitn == 9) want = 1'b1;
            else want = d[bitn-1];
            if (tx_serial2 !== want) bad++;
            if (tx_busy2 === 1'b1) n++;
            step(1);
        end
        chk("min_rate_wave", bad == 0, bad, 0);
        chk("min_rate_busy", n == 10 * S2 + 1, n, 10 * S2 + 1);

        chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
